multiport_register_file: RTL and testbench

//  Parametrised multi-port register file for the pipelined datapath: NRD combinational read ports
//  and NWR synchronous write ports. Adds a per-register pending scoreboard for hazard detection
//  and a sequenced clear engine that zeroes the file. Sits in the decode stage and replaces the

---
 rtl/multiport_register_file.sv | 118 +++++++++++
 tb/tb_multiport_register_file.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
// Multi-port register file with a pending-bit scoreboard and a sequenced clear engine.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module multiport_register_file #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NRD*AW-1:0]     rsel,
    output logic [NRD*DATA_W-1:0] rdat,
    output logic [NRD-1:0]        rd_pend,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*AW-1:0]     wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    input  logic                  sb_set,
    input  logic [AW-1:0]         sb_sel,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_done
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t            state, next_state;
    logic [AW-1:0]     cnt;
    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending;

    // Register 0 is never written, set pending or forwarded when it is hardwired to zero.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return !(ZERO_REG != 0 && a == '0);
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && clr_req)
                cnt <= '0;
            else if (state == SWEEP)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        clr_done   = 1'b0;
        case (state)
            IDLE:  if (clr_req) next_state = SWEEP;
            SWEEP: begin
                busy = 1'b1;
                if (cnt == AW'(NREGS - 1)) next_state = DONE;
            end
            DONE: begin
                clr_done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Later assignments win: write port 1 over port 0, scoreboard set over write clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
            pending <= '0;
        end else if (state == SWEEP) begin
            regs[cnt]    <= '0;
            pending[cnt] <= 1'b0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && addr_ok(wsel[j*AW +: AW])) begin
                    regs[wsel[j*AW +: AW]]    <= wdat[j*DATA_W +: DATA_W];
                    pending[wsel[j*AW +: AW]] <= 1'b0;
                end
            end
            if (sb_set && addr_ok(sb_sel))
                pending[sb_sel] <= 1'b1;
        end
    end

    always_comb begin
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] rd;
        logic              pd;
        rdat    = '0;
        rd_pend = '0;
        a       = '0;
        rd      = '0;
        pd      = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            a  = rsel[i*AW +: AW];
            rd = addr_ok(a) ? regs[a] : '0;
            pd = pending[a];
`ifdef REGFILE_BYPASS_EN
            // Highest matching write port is applied last and therefore wins.
            if (state != SWEEP && addr_ok(a)) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wen[j] && wsel[j*AW +: AW] == a) begin
                        rd = wdat[j*DATA_W +: DATA_W];
                        if (!(sb_set && sb_sel == a)) pd = 1'b0;
                    end
                end
            end
`endif
            rdat[i*DATA_W +: DATA_W] = rd;
            rd_pend[i]               = pd;
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file: directed steps then random traffic
// against an array-based reference model.
module tb_multiport_register_file;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int NRD    = 2;
    localparam int NWR    = 2;
    localparam int AW     = 5;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [NRD*AW-1:0]     rsel;
    logic [NRD*DATA_W-1:0] rdat;
    logic [NRD-1:0]        rd_pend;
    logic [NWR-1:0]        wen;
    logic [NWR*AW-1:0]     wsel;
    logic [NWR*DATA_W-1:0] wdat;
    logic                  sb_set;
    logic [AW-1:0]         sb_sel;
    logic                  clr_req;
    logic                  busy;
    logic                  clr_done;

    multiport_register_file #(
        .DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
    ) dut (
        .CLK(CLK), .RST(RST), .rsel(rsel), .rdat(rdat), .rd_pend(rd_pend),
        .wen(wen), .wsel(wsel), .wdat(wdat), .sb_set(sb_set), .sb_sel(sb_sel),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
    );

    always #5 CLK = ~CLK;

    // Reference model: register contents, pending flags, clear phase (0 idle, 1 sweep, 2 done).
    logic [DATA_W-1:0] m_regs [NREGS];
    bit                m_pend [NREGS];
    int                phase;
    int                idx;
    int                n_cmp = 0;
    int                n_bad = 0;
    logic              last_busy, last_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREGS; k++) begin
            m_regs[k] = '0;
            m_pend[k] = 1'b0;
        end
        phase = 0;
        idx   = 0;
    endtask

    task automatic model_edge();
        int a;
        if (phase == 1) begin
            m_regs[idx] = '0;
            m_pend[idx] = 1'b0;
            idx++;
            if (idx == NREGS) phase = 2;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                a = int'(wsel[j*AW +: AW]);
                if (wen[j] && a != 0) begin
                    m_regs[a] = wdat[j*DATA_W +: DATA_W];
                    m_pend[a] = 1'b0;
                end
            end
            if (sb_set && sb_sel != 0) m_pend[sb_sel] = 1'b1;
            if (phase == 2) phase = 0;
            else if (clr_req) begin
                phase = 1;
                idx   = 0;
            end
        end
    endtask

    task automatic idle_inputs();
        wen = '0; wsel = '0; wdat = '0; sb_set = 1'b0; sb_sel = '0; clr_req = 1'b0;
    endtask

    // Check all outputs against the model for the inputs now applied, then take one edge.
    task automatic cycle();
        int                a;
        logic [DATA_W-1:0] er;
        logic              ep;
        #1;
        for (int i = 0; i < NRD; i++) begin
            a  = int'(rsel[i*AW +: AW]);
            er = m_regs[a];
            ep = m_pend[a];
`ifdef REGFILE_BYPASS_EN
            if (phase != 1 && a != 0)
                for (int j = 0; j < NWR; j++)
                    if (wen[j] && int'(wsel[j*AW +: AW]) == a) begin
                        er = wdat[j*DATA_W +: DATA_W];
                        if (!(sb_set && int'(sb_sel) == a)) ep = 1'b0;
                    end
`endif
            chk($sformatf("rdat%0d_a%0d", i, a), 64'(rdat[i*DATA_W +: DATA_W]), 64'(er));
            chk($sformatf("rd_pend%0d_a%0d", i, a), 64'(rd_pend[i]), 64'(ep));
        end
        chk("busy", 64'(busy), 64'(phase == 1));
        chk("clr_done", 64'(clr_done), 64'(phase == 2));
        last_busy = busy;
        last_done = clr_done;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic scan_all();
        idle_inputs();
        for (int a = 0; a < NREGS; a++) begin
            rsel = {AW'(NREGS - 1 - a), AW'(a)};
            cycle();
        end
    endtask

    task automatic fill_index();
        idle_inputs();
        for (int a = 1; a < NREGS; a++) begin
            wen  = 2'b01;
            wsel = {AW'(0), AW'(a)};
            wdat = {32'h0, 32'(a)};
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        int nb, done_at;
        RST = 1'b1;
        rsel = '0;
        idle_inputs();
        model_reset();

        // 1: reset state
        @(negedge CLK);
        #1;
        chk("reset_rdat0", 64'(rdat[31:0]), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        RST = 1'b0;
        scan_all();

        // 2: single write, same-cycle and next-cycle read, write to r0 dropped
        wen = 2'b01; wsel = {AW'(0), AW'(5)}; wdat = {32'h0, 32'hDEADBEEF};
        rsel = {AW'(0), AW'(5)};
        cycle();
        idle_inputs();
        #1 chk("wr5_next", 64'(rdat[31:0]), 64'hDEADBEEF);
        cycle();
        wen = 2'b01; wsel = '0; wdat = {32'h0, 32'h12345678};
        cycle();
        idle_inputs();
        rsel = '0;
        #1 chk("wr0_dropped", 64'(rdat[31:0]), 64'h0);
        cycle();

        // 3: both ports write r7, port 1 wins
        wen = 2'b11; wsel = {AW'(7), AW'(7)}; wdat = {32'h22, 32'h11};
        rsel = {AW'(7), AW'(7)};
        cycle();
        idle_inputs();
        #1 chk("dual_wr7", 64'(rdat[63:32]), 64'h22);
        cycle();

        // 4: scoreboard set, set+write, write alone
        sb_set = 1'b1; sb_sel = 9; rsel = {AW'(9), AW'(9)};
        cycle();
        idle_inputs();
        #1 chk("pend9_set", 64'(rd_pend[0]), 64'h1);
        cycle();
        wen = 2'b01; wsel = {AW'(0), AW'(9)}; wdat = {32'h0, 32'h99}; sb_set = 1'b1; sb_sel = 9;
        cycle();
        idle_inputs();
        #1 chk("pend9_set_wins", 64'(rd_pend[1]), 64'h1);
        cycle();
        wen = 2'b01; wsel = {AW'(0), AW'(9)}; wdat = {32'h0, 32'h98};
        cycle();
        idle_inputs();
        #1 chk("pend9_cleared", 64'(rd_pend[0]), 64'h0);
        cycle();
        sb_set = 1'b1; sb_sel = 0; rsel = '0;
        cycle();
        idle_inputs();
        #1 chk("pend0_ignored", 64'(rd_pend[0]), 64'h0);
        cycle();

        // 5: fill, sweep timing, write during sweep dropped
        fill_index();
        sb_set = 1'b1; sb_sel = 12;
        cycle();
        idle_inputs();
        clr_req = 1'b1;
        rsel = {AW'(31), AW'(1)};
        cycle();
        clr_req = 1'b0;
        nb = 0;
        done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                wen = 2'b11; wsel = {AW'(30), AW'(3)}; wdat = {32'hBBBB, 32'hAAAA};
                sb_set = 1'b1; sb_sel = 31; clr_req = 1'b1;
            end else idle_inputs();
            rsel = {AW'(31 - (k % 32)), AW'(k % 32)};
            cycle();
            if (last_busy) nb++;
            if (last_done) begin
                done_at = k;
                break;
            end
        end
        chk("sweep_busy_cycles", 64'(nb), 64'd32);
        chk("sweep_done_cycle", 64'(done_at), 64'd33);
        scan_all();
        rsel = {AW'(30), AW'(3)};
        #1 chk("sweep_wr_dropped", 64'(rdat), 64'h0);
        cycle();

        // 6: reset during sweep aborts it
        fill_index();
        clr_req = 1'b1;
        cycle();
        idle_inputs();
        repeat (10) cycle();
        rsel = {AW'(20), AW'(15)};
        #2 RST = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(clr_done), 64'h0);
        chk("abort_rdat", 64'(rdat), 64'h0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        scan_all();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            wen    = NWR'($urandom_range(0, 3));
            wsel   = NWR*AW'($urandom);
            wdat   = {$urandom, $urandom};
            sb_set = ($urandom_range(0, 3) == 0);
            sb_sel = AW'($urandom);
            clr_req = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) rsel = {wsel[AW +: AW], wsel[0 +: AW]};
            else rsel = NRD*AW'($urandom);
            cycle();
        end
        idle_inputs();
        repeat (40) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
